// File: rtl/shift_sequencer.sv
// Multicycle sequencer for the RegDesloc shifter: load, step the shift in
// chunks of at most STEP_MAX bits, then pulse the result write.
module shift_sequencer #(
    parameter int STEP_MAX = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] shamt,
    input  logic [4:0] rs_amt,
    input  logic       abort,
    output logic [2:0] SHIFTER_control,
    output logic [4:0] SHIFTER_n,
    output logic       M_SHIFTER,
    output logic       result_wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [4:0] STEP = 5'(STEP_MAX);

    localparam logic [2:0] CTRL_HOLD = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;
    localparam logic [2:0] CTRL_LEFT = 3'b010;
    localparam logic [2:0] CTRL_SRL  = 3'b011;
    localparam logic [2:0] CTRL_SRA  = 3'b100;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ERR
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic [2:0] op_q, op_d;
    logic [4:0] step;

    logic [2:0] ctrl_q, ctrl_d;
    logic [4:0] n_q, n_d;
    logic       msh_q, msh_d;
    logic       wr_q, wr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // Direction and source are pure functions of the latched op.
    function automatic logic [2:0] dir_of(input logic [2:0] o);
        case (o)
            OP_SLL, OP_SLLV, OP_LUI: dir_of = CTRL_LEFT;
            OP_SRL, OP_SRLV:         dir_of = CTRL_SRL;
            OP_SRA, OP_SRAV:         dir_of = CTRL_SRA;
            default:                 dir_of = CTRL_HOLD;
        endcase
    endfunction

    function automatic logic [4:0] min_step(input logic [4:0] r);
        min_step = (r < STEP) ? r : STEP;
    endfunction

    assign step = min_step(rem_q);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;

        if (abort) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d = op;
                        case (op)
                            OP_SLL, OP_SRL, OP_SRA:    rem_d = shamt;
                            OP_SLLV, OP_SRLV, OP_SRAV: rem_d = rs_amt;
                            OP_LUI:                    rem_d = 5'd16;
                            default:                   rem_d = '0;
                        endcase
                        state_d = (op == OP_ILL) ? S_ERR : S_LOAD;
                    end
                end
                S_LOAD:  state_d = (rem_q != '0) ? S_SHIFT : S_DONE;
                S_SHIFT: begin
                    rem_d   = rem_q - step;
                    state_d = (rem_d == '0) ? S_DONE : S_SHIFT;
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ctrl_d = CTRL_HOLD;
        n_d    = '0;
        msh_d  = 1'b0;
        wr_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            S_LOAD: begin
                ctrl_d = CTRL_LOAD;
                msh_d  = (op_d == OP_LUI);
                busy_d = 1'b1;
            end
            S_SHIFT: begin
                ctrl_d = dir_of(op_d);
                n_d    = min_step(rem_d);
                msh_d  = (op_d == OP_LUI);
                busy_d = 1'b1;
            end
            S_DONE: begin
                wr_d   = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            S_ERR: begin
                err_d  = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            op_q    <= '0;
            ctrl_q  <= CTRL_HOLD;
            n_q     <= '0;
            msh_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            n_q     <= n_d;
            msh_q   <= msh_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign SHIFTER_control = ctrl_q;
    assign SHIFTER_n       = n_q;
    assign M_SHIFTER       = msh_q;
    assign result_wr       = wr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: three instances (STEP_MAX 31/8/4),
// expected per-cycle output words are queued with their cycle number.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] abort = '0;
    logic [2:0] op = '0;
    logic [4:0] shamt = '0;
    logic [4:0] rs_amt = '0;

    logic [2:0]  ctrl [3];
    logic [4:0]  n    [3];
    logic        msh  [3];
    logic        wr   [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic        er   [3];
    logic [12:0] obs  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SM = (g == 0) ? 31 : ((g == 1) ? 8 : 4);
        shift_sequencer #(.STEP_MAX(SM)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start[g]),
            .op             (op),
            .shamt          (shamt),
            .rs_amt         (rs_amt),
            .abort          (abort[g]),
            .SHIFTER_control(ctrl[g]),
            .SHIFTER_n      (n[g]),
            .M_SHIFTER      (msh[g]),
            .result_wr      (wr[g]),
            .busy           (bsy[g]),
            .done           (dn[g]),
            .err            (er[g])
        );
        assign obs[g] = {bsy[g], dn[g], er[g], wr[g], msh[g], ctrl[g], n[g]};
    end

    // obs = {busy, done, err, result_wr, M_SHIFTER, ctrl[2:0], n[4:0]}
    localparam logic [12:0] DN = 13'b1_1_0_1_0_000_00000;
    localparam logic [12:0] ER = 13'b1_1_1_0_0_000_00000;

    function automatic logic [12:0] ld(input logic m);
        return {1'b1, 1'b0, 1'b0, 1'b0, m, 3'b001, 5'd0};
    endfunction

    function automatic logic [12:0] sh(input logic m, input logic [2:0] c, input logic [4:0] d);
        return {1'b1, 1'b0, 1'b0, 1'b0, m, c, d};
    endfunction

    typedef struct {
        int          inst;
        int          cyc;
        logic [12:0] obs;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (obs[i] != '0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out inst=%0d cyc=%0d got=%h expected idle", i, cyc, obs[i]);
                end else begin
                    e = q.pop_front();
                    if (e.inst != i || e.cyc != cyc || e.obs != obs[i]) begin
                        errors++;
                        $display("FAIL seq got inst=%0d cyc=%0d obs=%h expected inst=%0d cyc=%0d obs=%h",
                                 i, cyc, obs[i], e.inst, e.cyc, e.obs);
                    end
                end
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_out inst=%0d cyc=%0d got=idle expected=%h", e.inst, e.cyc, e.obs);
        end
    end

    task automatic push(input int i, input int base, input int off, input logic [12:0] o);
        exp_t x;
        x.inst = i;
        x.cyc  = base + off;
        x.obs  = o;
        q.push_back(x);
    endtask

    // One-cycle start; inputs are scrambled afterwards to prove they were latched.
    task automatic go(input int i, input logic [2:0] o, input logic [4:0] sa,
                      input logic [4:0] ra, output int base);
        @(posedge clk); #1;
        op = o; shamt = sa; rs_amt = ra; start[i] = 1'b1;
        base = cyc + 1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        op = ~o; shamt = ~sa; rs_amt = ~ra;
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] != '0) begin
                errors++;
                $display("FAIL %s inst=%0d got=%h expected=0000", name, i, obs[i]);
            end
        end
    endtask

    initial begin
        #3;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // SLL 5, single step
        go(0, 3'b000, 5'd5, 5'd0, b);
        push(0, b, 0, ld(0));
        push(0, b, 1, sh(0, 3'b010, 5'd5));
        push(0, b, 2, DN);
        repeat (5) @(posedge clk);

        // SRA 20 on an 8-bit step shifter
        go(1, 3'b010, 5'd20, 5'd3, b);
        push(1, b, 0, ld(0));
        push(1, b, 1, sh(0, 3'b100, 5'd8));
        push(1, b, 2, sh(0, 3'b100, 5'd8));
        push(1, b, 3, sh(0, 3'b100, 5'd4));
        push(1, b, 4, DN);
        repeat (7) @(posedge clk);

        // LUI: immediate source, fixed 16 left
        go(0, 3'b110, 5'd7, 5'd2, b);
        push(0, b, 0, ld(1));
        push(0, b, 1, sh(1, 3'b010, 5'd16));
        push(0, b, 2, DN);
        repeat (5) @(posedge clk);

        // SRAV with rs_amt 0: no shift cycles
        go(0, 3'b101, 5'd9, 5'd0, b);
        push(0, b, 0, ld(0));
        push(0, b, 1, DN);
        repeat (4) @(posedge clk);

        // illegal op
        go(0, 3'b111, 5'd4, 5'd4, b);
        push(0, b, 0, ER);
        repeat (4) @(posedge clk);

        // SLL 20 on step 8, start pulsed during SHIFT and during DONE
        go(1, 3'b000, 5'd20, 5'd1, b);
        push(1, b, 0, ld(0));
        push(1, b, 1, sh(0, 3'b010, 5'd8));
        push(1, b, 2, sh(0, 3'b010, 5'd8));
        push(1, b, 3, sh(0, 3'b010, 5'd4));
        push(1, b, 4, DN);
        @(posedge clk); #1; start[1] = 1'b1;
        @(posedge clk); #1; start[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1; start[1] = 1'b1;
        @(posedge clk); #1; start[1] = 1'b0;
        repeat (5) @(posedge clk);

        // abort in IDLE cancels simultaneous start
        @(posedge clk); #1;
        op = 3'b000; shamt = 5'd3; start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; abort[0] = 1'b0;
        repeat (5) @(posedge clk);

        // SRL 31 on step 4, abort in third SHIFT cycle
        go(2, 3'b001, 5'd31, 5'd0, b);
        push(2, b, 0, ld(0));
        push(2, b, 1, sh(0, 3'b011, 5'd4));
        push(2, b, 2, sh(0, 3'b011, 5'd4));
        push(2, b, 3, sh(0, 3'b011, 5'd4));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1; abort[2] = 1'b1;
        @(posedge clk); #1; abort[2] = 1'b0;
        repeat (6) @(posedge clk);

        // same op, async reset mid-SHIFT
        go(2, 3'b001, 5'd31, 5'd0, b);
        push(2, b, 0, ld(0));
        push(2, b, 1, sh(0, 3'b011, 5'd4));
        push(2, b, 2, sh(0, 3'b011, 5'd4));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);

        // recovery after reset: SLL 4, exactly one step
        go(2, 3'b000, 5'd4, 5'd0, b);
        push(2, b, 0, ld(0));
        push(2, b, 1, sh(0, 3'b010, 5'd4));
        push(2, b, 2, DN);
        repeat (5) @(posedge clk);

        // SRLV 9 on step 4: partial last step
        go(2, 3'b100, 5'd2, 5'd9, b);
        push(2, b, 0, ld(0));
        push(2, b, 1, sh(0, 3'b011, 5'd4));
        push(2, b, 2, sh(0, 3'b011, 5'd4));
        push(2, b, 3, sh(0, 3'b011, 5'd1));
        push(2, b, 4, DN);
        repeat (8) @(posedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d pending expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
